// File: rtl/grostl_pkg.sv
// grostl_pkg: shared state encoding, counter types and Groestl-256 sizing constants
// for the column sequencer.
package grostl_pkg;
    typedef enum logic [1:0] {IDLE, RUN, RWAIT, DONE} grostl_seq_state_t;
    typedef logic [3:0] grostl_rnd_t;
    typedef logic [2:0] grostl_col_t;
    localparam int GROSTL256_ROUNDS = 10;
    localparam int GROSTL_COLS = 8;
endpackage

// File: rtl/grostl_seq_counter.sv
// grostl_seq_counter: nested col/pq/rnd counter for the column sequencer.
// GROSTL_PQ_INTERLEAVE_EN selects P/Q interleaved issue order (default: all P, then all Q).
module grostl_seq_counter
    import grostl_pkg::*;
#(
    parameter int NUM_ROUNDS = GROSTL256_ROUNDS,
    parameter int NUM_COLS = GROSTL_COLS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       step,
    input  logic       rnd_inc,
    output logic       pq,
    output logic [3:0] rnd,
    output logic [2:0] col,
    output logic       last_col,
    output logic       rnd_last
);
    localparam grostl_col_t COL_MAX = grostl_col_t'(NUM_COLS - 1);
    localparam grostl_rnd_t RND_MAX = grostl_rnd_t'(NUM_ROUNDS - 1);

    logic        pq_n;
    grostl_col_t col_n;
    grostl_col_t col_inc;

    // Explicit wrap keeps the column counter from ever carrying out of 3 bits.
    assign col_inc = (col == COL_MAX) ? '0 : col + 3'd1;

`ifdef GROSTL_PQ_INTERLEAVE_EN
    always_comb begin
        pq_n  = ~pq;
        col_n = pq ? col_inc : col;
    end
`else
    always_comb begin
        pq_n  = pq | (col == COL_MAX);
        col_n = col_inc;
    end
`endif

    // step is never asserted on the final column of a round, so the round
    // boundary is handled only by rnd_inc / clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pq       <= 1'b0;
            rnd      <= '0;
            col      <= '0;
            last_col <= 1'b0;
        end else if (clr) begin
            pq       <= 1'b0;
            rnd      <= '0;
            col      <= '0;
            last_col <= 1'b0;
        end else if (rnd_inc) begin
            pq       <= 1'b0;
            rnd      <= rnd + 4'd1;
            col      <= '0;
            last_col <= 1'b0;
        end else if (step) begin
            pq       <= pq_n;
            col      <= col_n;
            last_col <= pq_n & (col_n == COL_MAX);
        end
    end

    assign rnd_last = (rnd == RND_MAX);
endmodule

// File: rtl/grostl_col_sequencer.sv
// grostl_col_sequencer: issues every column of every P and Q round, stalling at each
// round boundary for writeback. GROSTL_PQ_INTERLEAVE_EN selects interleaved P/Q order.
module grostl_col_sequencer
    import grostl_pkg::*;
#(
    parameter int NUM_ROUNDS = GROSTL256_ROUNDS,
    parameter int NUM_COLS = GROSTL_COLS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       col_rdy,
    input  logic       rnd_ack,
    output logic       col_vld,
    output logic       pq,
    output logic [3:0] rnd,
    output logic [2:0] col,
    output logic       last_col,
    output logic       busy,
    output logic       done
);
    grostl_seq_state_t state;
    logic accept;
    logic clr;
    logic step;
    logic rnd_inc;
    logic rnd_last;

    assign accept  = (state == RUN) & col_rdy;
    assign clr     = ((state == IDLE) & start) | (accept & last_col & rnd_last);
    assign step    = accept & ~last_col;
    assign rnd_inc = (state == RWAIT) & rnd_ack;

    grostl_seq_counter #(
        .NUM_ROUNDS(NUM_ROUNDS),
        .NUM_COLS  (NUM_COLS)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .step    (step),
        .rnd_inc (rnd_inc),
        .pq      (pq),
        .rnd     (rnd),
        .col     (col),
        .last_col(last_col),
        .rnd_last(rnd_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            col_vld <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state   <= RUN;
                    col_vld <= 1'b1;
                    busy    <= 1'b1;
                end
                RUN: if (col_rdy & last_col) begin
                    state   <= rnd_last ? DONE : RWAIT;
                    col_vld <= 1'b0;
                    done    <= rnd_last;
                end
                RWAIT: if (rnd_ack) begin
                    state   <= RUN;
                    col_vld <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
